// File: rtl/sn74ls596_loader.sv
`default_nettype none
// ============================================================================
// Module   : sn74ls596_loader
// Purpose  : Serialises parallel words into a cascade of NDEV sn74ls596
//            shift/storage registers. Each word is shifted out MSB first on
//            ser/sck and then transferred to the device outputs with an rck
//            pulse. Also sequences shift-register clears (sclr) and drives
//            the active-low output-enable pin g from the oe request.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   NDEV       number of cascaded '596 devices (word width W = 8*NDEV)
//   DIV        clk cycles per sck/rck/sclr half-period (DIV >= 1)
// Ports
//   clk        system clock, all state on rising edge
//   clr        asynchronous active-low reset
//   din        parallel word, din[W-1] shifted first
//   valid      load request, qualified by ready
//   clear_req  clear request, qualified by ready (wins over valid)
//   oe         output enable request, 1 = device outputs driven
//   ready      high only while idle
//   busy       complement of ready
//   ser        serial data to the first device
//   sck        shift clock, idle high, devices shift on the rising edge
//   rck        storage clock, idle high, devices latch on the rising edge
//   sclr       shift-register clear, active-low
//   g          output enable to the devices, active-low
// ============================================================================
module sn74ls596_loader #(
    parameter int NDEV = 1,
    parameter int DIV  = 1
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [8*NDEV-1:0]   din,
    input  logic                valid,
    input  logic                clear_req,
    input  logic                oe,
    output logic                ready,
    output logic                busy,
    output logic                ser,
    output logic                sck,
    output logic                rck,
    output logic                sclr,
    output logic                g
);

    localparam int W  = 8 * NDEV;
    localparam int BW = $clog2(W);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,    // waiting for a request, ready high
        SLO  = 3'd1,    // sck low, ser presenting the current bit
        SHI  = 3'd2,    // sck high, devices have shifted on entry
        CLR  = 3'd3,    // sclr low, device shift registers clearing
        LAT  = 3'd4     // rck low, storage transfer on exit
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [DW-1:0]  divcnt;
    logic [DW-1:0]  divcnt_nx;
    logic [BW-1:0]  bitcnt;
    logic [BW-1:0]  bitcnt_nx;
    logic [W-1:0]   shreg;
    logic [W-1:0]   shreg_nx;
    logic           ser_nx;
    logic           div_done;

    // Every non-idle state lasts exactly DIV clk cycles.
    assign div_done = (divcnt == DIV_LAST);

    // ------------------------------------------------------------------
    // State register and output flops.
    // The pin outputs are registered from the next state, so each pin is
    // a direct flop output and changes on the same edge the state does.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state  <= IDLE;
            divcnt <= '0;
            bitcnt <= '0;
            shreg  <= '0;
            ser    <= 1'b0;
            sck    <= 1'b1;
            rck    <= 1'b1;
            sclr   <= 1'b1;
            ready  <= 1'b1;
            busy   <= 1'b0;
            g      <= 1'b1;
        end else begin
            state  <= state_nx;
            divcnt <= divcnt_nx;
            bitcnt <= bitcnt_nx;
            shreg  <= shreg_nx;
            ser    <= ser_nx;
            sck    <= (state_nx != SLO);
            rck    <= (state_nx != LAT);
            sclr   <= (state_nx != CLR);
            ready  <= (state_nx == IDLE);
            busy   <= (state_nx != IDLE);
            // Output enable is independent of the sequencer.
            g      <= ~oe;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic.
    // ------------------------------------------------------------------
    always_comb begin
        state_nx  = state;
        divcnt_nx = div_done ? '0 : (divcnt + DW'(1));
        bitcnt_nx = bitcnt;
        shreg_nx  = shreg;

        case (state)
            IDLE: begin
                divcnt_nx = '0;
                // A clear request takes the slot; a simultaneous word
                // stays pending on valid until ready returns.
                if (clear_req) begin
                    state_nx = CLR;
                end else if (valid) begin
                    shreg_nx  = din;
                    bitcnt_nx = BIT_LAST;
                    state_nx  = SLO;
                end
            end
            SLO: begin
                if (div_done) begin
                    state_nx = SHI;
                end
            end
            SHI: begin
                if (div_done) begin
                    shreg_nx = {shreg[W-2:0], 1'b0};
                    if (bitcnt == '0) begin
                        state_nx = LAT;
                    end else begin
                        bitcnt_nx = bitcnt - BW'(1);
                        state_nx  = SLO;
                    end
                end
            end
            CLR: begin
                // Go through LAT so the cleared zeros reach the outputs.
                if (div_done) begin
                    state_nx = LAT;
                end
            end
            LAT: begin
                if (div_done) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx  = IDLE;
                divcnt_nx = '0;
            end
        endcase
    end

    // ser is updated only on entry to SLO (the sck falling edge), which
    // gives DIV cycles of setup and DIV cycles of hold around each rising
    // sck edge. It holds its last value everywhere else.
    always_comb begin
        ser_nx = ser;
        if (state_nx == SLO) begin
            ser_nx = shreg_nx[W-1];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sn74ls596_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sn74ls596_loader
// Purpose  : Self-checking bench for sn74ls596_loader. Two instances are
//            exercised (NDEV=1/DIV=1 and NDEV=2/DIV=3). A behavioural model
//            of the '596 chain (shift on sck rise, clear on sclr low, store
//            on rck rise) and a timing model derived from the pulse-position
//            formulas are checked every cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_sn74ls596_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]        clr;
    logic [1:0]        valid;
    logic [1:0]        clear_req;
    logic [1:0]        oe;
    logic [1:0][15:0]  din_s;
    logic [1:0]        ready, busy, ser, sck, rck, sclr, g;

    sn74ls596_loader #(.NDEV(1), .DIV(1)) u_dut0 (
        .clk(clk), .clr(clr[0]), .din(din_s[0][7:0]), .valid(valid[0]),
        .clear_req(clear_req[0]), .oe(oe[0]), .ready(ready[0]), .busy(busy[0]),
        .ser(ser[0]), .sck(sck[0]), .rck(rck[0]), .sclr(sclr[0]), .g(g[0])
    );

    sn74ls596_loader #(.NDEV(2), .DIV(3)) u_dut1 (
        .clk(clk), .clr(clr[1]), .din(din_s[1]), .valid(valid[1]),
        .clear_req(clear_req[1]), .oe(oe[1]), .ready(ready[1]), .busy(busy[1]),
        .ser(ser[1]), .sck(sck[1]), .rck(rck[1]), .sclr(sclr[1]), .g(g[1])
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model state ----------------
    int          wid [2] = '{8, 16};
    int          dv  [2] = '{1, 3};
    logic [15:0] chain [2];
    logic [15:0] store [2];
    logic [15:0] exp_word [2];
    logic        p_sck [2], p_rck [2], p_sclr [2], p_ser [2], p_oe [2];
    bit          oe_ok [2];
    int          kind [2];      // 0 none, 1 load, 2 clear
    int          t [2];         // cycles since acceptance
    int          nrise [2];

    function automatic logic [15:0] wmask(input int i);
        return (i == 0) ? 16'h00FF : 16'hFFFF;
    endfunction

    task automatic monitor(input int i);
        logic e_sck, e_rck, e_sclr, e_rdy, two, lowg;
        int   d, w, tend;
        d = dv[i];
        w = wid[i];
        if (!clr[i]) begin
            kind[i]  = 0;
            oe_ok[i] = 1'b0;
            p_sck[i] = 1'b1; p_rck[i] = 1'b1; p_sclr[i] = 1'b1; p_ser[i] = 1'b0;
            return;
        end
        if (oe_ok[i]) begin
            lowg = !p_oe[i];
            check("g", g[i], lowg);
        end
        p_oe[i]  = oe[i];
        oe_ok[i] = 1'b1;

        e_sck = 1'b1; e_rck = 1'b1; e_sclr = 1'b1; e_rdy = 1'b1;
        if (kind[i] != 0) begin
            t[i]++;
            tend = (kind[i] == 1) ? 1 + (2*w + 1)*d : 1 + 2*d;
            if (kind[i] == 1) begin
                if (t[i] >= 1 && t[i] < 1 + 2*w*d && ((t[i] - 1) / d) % 2 == 0) e_sck = 1'b0;
                if (t[i] >= 1 + 2*w*d && t[i] < 1 + (2*w + 1)*d) e_rck = 1'b0;
            end else begin
                if (t[i] >= 1 && t[i] <= d) e_sclr = 1'b0;
                if (t[i] > d && t[i] <= 2*d) e_rck = 1'b0;
            end
            e_rdy = (t[i] >= tend);
            if (t[i] >= tend) kind[i] = 0;
        end
        check("sck", sck[i], e_sck);
        check("rck", rck[i], e_rck);
        check("sclr", sclr[i], e_sclr);
        check("ready", ready[i], e_rdy);
        check("busy", busy[i], !e_rdy);

        if (sck[i] !== p_sck[i]) begin
            two = (rck[i] !== p_rck[i]) || (sclr[i] !== p_sclr[i]);
            check("sck_alone", two, 0);
        end
        if (ser[i] !== p_ser[i]) check("ser_on_fall", p_sck[i] && !sck[i], 1);

        // '596 chain behaviour
        if (!sclr[i]) chain[i] = '0;
        if (!p_sck[i] && sck[i]) begin
            nrise[i]++;
            chain[i] = {chain[i][14:0], ser[i]};
            if (nrise[i] >= 1 && nrise[i] <= w)
                check("ser_bit", ser[i], exp_word[i][w - nrise[i]]);
        end
        if (!p_rck[i] && rck[i]) begin
            store[i] = chain[i] & wmask(i);
            check("q", store[i], exp_word[i]);
        end
        p_sck[i] = sck[i]; p_rck[i] = rck[i]; p_sclr[i] = sclr[i]; p_ser[i] = ser[i];

        // acceptance at the coming edge
        if (e_rdy && (clear_req[i] || valid[i])) begin
            kind[i]     = clear_req[i] ? 2 : 1;
            exp_word[i] = clear_req[i] ? 16'h0000 : (din_s[i] & wmask(i));
            t[i]        = 0;
            nrise[i]    = 0;
        end
    endtask

    always @(negedge clk) begin
        monitor(0);
        monitor(1);
    end

    // ---------------- stimulus helpers ----------------
    // Wait for ready at a falling edge, let the following rising edge
    // accept whatever request is applied, return just after it.
    task automatic sync_ready(input int i);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready[i] && n < 400);
        if (!ready[i]) check("ready_timeout", ready[i], 1);
        @(posedge clk);
        #2;
    endtask

    task automatic load(input int i, input logic [15:0] w);
        din_s[i] = w;
        valid[i] = 1'b1;
        sync_ready(i);
        valid[i] = 1'b0;
    endtask

    task automatic do_clear(input int i);
        clear_req[i] = 1'b1;
        sync_ready(i);
        clear_req[i] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [15:0] pre;
        clr = 2'b00; valid = 2'b00; clear_req = 2'b00; oe = 2'b00; din_s = '0;
        for (int i = 0; i < 2; i++) begin
            chain[i] = '0; store[i] = '0; exp_word[i] = '0; kind[i] = 0; t[i] = 0; nrise[i] = 0;
        end
        repeat (3) @(posedge clk);
        #2;
        for (int i = 0; i < 2; i++) begin
            check("rst_ready", ready[i], 1);
            check("rst_busy", busy[i], 0);
            check("rst_ser", ser[i], 0);
            check("rst_sck", sck[i], 1);
            check("rst_rck", rck[i], 1);
            check("rst_sclr", sclr[i], 1);
            check("rst_g", g[i], 1);
        end
        clr = 2'b11;
        repeat (2) @(posedge clk);
        #2;

        // single word
        load(0, 16'h0001);
        sync_ready(0);
        check("q_01", store[0], 16'h0001);

        // back-to-back with valid held
        din_s[0] = 16'h000F;
        valid[0] = 1'b1;
        sync_ready(0);
        din_s[0] = 16'h00FC;
        sync_ready(0);
        valid[0] = 1'b0;
        check("q_0f", store[0], 16'h000F);
        sync_ready(0);
        check("q_fc", store[0], 16'h00FC);

        // clear and valid together
        din_s[0] = 16'h005A;
        clear_req[0] = 1'b1;
        valid[0] = 1'b1;
        sync_ready(0);
        clear_req[0] = 1'b0;
        check("rdy_after_clr", ready[0], 0);
        sync_ready(0);
        valid[0] = 1'b0;
        check("q_clr", store[0], 16'h0000);
        sync_ready(0);
        check("q_5a", store[0], 16'h005A);

        // oe toggling during a load
        load(0, 16'h00C3);
        oe[0] = 1'b1;
        repeat (3) @(posedge clk);
        #2 oe[0] = 1'b0;
        repeat (4) @(posedge clk);
        #2 oe[0] = 1'b1;
        sync_ready(0);
        check("q_c3", store[0], 16'h00C3);
        check("g_on", g[0], 0);

        // two devices, DIV=3
        load(1, 16'hA55A);
        n = 0;
        while (n < 300) begin
            @(negedge clk);
            if (!busy[1]) break;
            n++;
        end
        check("busy_len", n, 99);
        @(posedge clk);
        #2;
        check("q_dev0", store[1][7:0], 8'h5A);
        check("q_dev1", store[1][15:8], 8'hA5);

        // reset in the middle of bit 4
        pre = store[0];
        load(0, 16'h003C);
        repeat (6) @(posedge clk);
        #2;
        check("pre_abort_sck", sck[0], 0);
        clr[0] = 1'b0;
        #1;
        check("abort_sck", sck[0], 1);
        check("abort_rck", rck[0], 1);
        check("abort_sclr", sclr[0], 1);
        check("abort_g", g[0], 1);
        check("abort_ready", ready[0], 1);
        @(negedge clk);
        @(posedge clk);
        #2 clr[0] = 1'b1;
        check("q_keep", store[0], pre);
        load(0, 16'h0080);
        sync_ready(0);
        check("q_80", store[0], 16'h0080);

        // randomized traffic on both instances
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < ((i == 0) ? 40 : 12); k++) begin
                int r;
                r = $urandom_range(0, 9);
                oe[i] = 1'($urandom);
                din_s[i] = 16'($urandom);
                if (r == 0) begin
                    clear_req[i] = 1'b1;
                    valid[i] = 1'b1;
                    sync_ready(i);
                    clear_req[i] = 1'b0;
                    sync_ready(i);
                    valid[i] = 1'b0;
                end else if (r < 3) begin
                    do_clear(i);
                end else begin
                    load(i, din_s[i]);
                end
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #2;
            end
            sync_ready(i);
        end

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
